lsb_queue: RTL and testbench
============================

// Module: lsb_queue
// PURPOSE
//  Parametrised load/store queue between decoder dispatch, CDB/ROB and the memory fetch controller.
//  Holds DEPTH memory ops in program order and snoops the CDB for operands.
//  Reports load data and store-ready to the ROB; writes stores to memory only after ROB commit.
//  Committed stores survive a flush.
// PARAMETERS
//  DEPTH   8   entries; power of two, >=2
//  TAG_W   5   ROB tag width; tag 0 = "value ready"
//  OP_W    6   opcode width, codes from parameters.v (LB..LW, SB..SW)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      reset, asynchronous, active-high
//  flush_in     in   1      exception/mispredict: drop uncommitted entries
//  disp_valid   in   1      dispatch one op this cycle
//  disp_op      in   OP_W   load/store opcode
//  disp_tag     in   TAG_W  ROB tag of op (nonzero)
//  disp_imm     in   32     offset; bits[11:0] sign-extended
//  disp_q1/q2   in   TAG_W  base/store-data producer tags (0 = value valid)
//  disp_v1/v2   in   32     base/store-data values
//  full_out     out  1      no free entry
//  cdb_valid    in   1      CDB broadcast
//  cdb_tag      in   TAG_W  broadcast tag
//  cdb_data     in   32     broadcast value
//  commit_valid in   1      ROB commits a store
//  commit_tag   in   TAG_W  tag of committed store
//  mem_req      out  1      memory request pending
//  mem_we       out  1      1 = store
//  mem_addr     out  32     byte address
//  mem_wdata    out  32     store data
//  mem_size     out  2      0=word, 1=byte, 2=half
//  mem_ack      in   1      one-cycle completion; mem_rdata valid
//  mem_rdata    in   32     load data, low-justified
//  res_valid    out  1      result to ROB/CDB
//  res_tag      out  TAG_W  result tag
//  res_data     out  32     load value; 0 for store-ready
// BEHAVIOUR
//  Reset: pointers/count 0, all entries invalid; full_out=0, mem_req=0, mem_we=0, mem_addr=0,
//   mem_wdata=0, mem_size=0, res_valid=0, res_tag=0, res_data=0.
//  Queue: head/tail with wrap bit; count 0..DEPTH; full_out = (count==DEPTH), combinational.
//  Dispatch: accepted if disp_valid & !full_out & !flush_in; enqueue at tail.
//   A disp_q matching a same-cycle cdb_tag captures cdb_data with q=0.
//  Snoop: each cycle every valid entry with q==cdb_tag!=0 takes cdb_data, q<=0.
//  addr = v1 + sext(imm[11:0]), 32-bit wrap.
//  Store-ready: oldest valid store with q1=q2=0 and !reported gets res_valid, res_data=0; reported<=1.
//  Commit: commit_valid & tag==oldest uncommitted store -> committed<=1.
//   A mismatching commit_tag is ignored.
//  Issue, head only, one outstanding op:
//   load at head with q1=0 -> mem_req=1, mem_we=0.
//   committed store at head -> mem_req=1, mem_we=1, mem_wdata=v2.
//   Fields hold stable until mem_ack.
//  On mem_ack: mem_req<=0. Load -> next cycle res_valid, res_data extended by op (LB/LH sign,
//   LBU/LHU zero, LW whole); head advances. Store -> head advances, no result.
//  res_valid is a 1-cycle pulse. Load result beats store-ready in the same cycle; store-ready retries.
//  FSM: IDLE -> WAIT_ACK (mem_req) -> RESP (load only, 1 cycle) -> IDLE. Store WAIT_ACK -> IDLE.
//  Flush: tail <= head + number of committed stores. Uncommitted entries invalid; res_valid<=0.
//   In-flight load: state DRAIN, keep mem_req to ack, discard data, then IDLE.
//   In-flight committed store completes normally.
//  Simultaneous dispatch+dequeue at full: dequeue first, dispatch still blocked by full_out this cycle.
//  rst mid-transaction: immediate return to reset state; memory side must tolerate dropped req.
// STRUCTURE
//  Shared pkg lsq_pkg: opcode constants, mem_size encodings, entry struct {valid,op,tag,imm,q1,v1,q2,v2,
//   reported,committed}, state enum.
//  Sub-module lsq_load_ext: combinational byte/half extension by op.
// TESTING
//  LW ready, imm=-4, v1=0x104 -> mem_addr=0x100, size 0; ack rdata=0xDEADBEEF -> res 0xDEADBEEF next cycle.
//  LB rdata=0x80 -> res_data=0xFFFFFF80. LBU -> 0x00000080. LH 0x8001 -> 0xFFFF8001.
//  SW q2=7, CDB tag7=0x55 -> store-ready res(tag); no mem_req before commit_tag; after commit -> we=1, wdata=0x55.
//  Fill DEPTH entries -> full_out=1, extra dispatch dropped; one dequeue -> full_out=0, wrap dispatch OK.
//  2 committed stores + 3 uncommitted ops, flush -> count=2, both stores written, no res for flushed ops.
//  Flush while load in WAIT_ACK -> mem_req held to ack, no res_valid, next head op issues after.

Source files
------------

// File: rtl/lsq_pkg.sv
// Shared definitions for the load/store queue: opcodes, memory size codes,
// queue entry layout, control FSM states and small opcode decode helpers.
package lsq_pkg;

    localparam int LSQ_TAG_W = 5;
    localparam int LSQ_OP_W  = 6;

    // Memory opcodes handled by the queue
    localparam logic [LSQ_OP_W-1:0] OP_LB  = 6'd1;
    localparam logic [LSQ_OP_W-1:0] OP_LH  = 6'd2;
    localparam logic [LSQ_OP_W-1:0] OP_LW  = 6'd3;
    localparam logic [LSQ_OP_W-1:0] OP_LBU = 6'd4;
    localparam logic [LSQ_OP_W-1:0] OP_LHU = 6'd5;
    localparam logic [LSQ_OP_W-1:0] OP_SB  = 6'd6;
    localparam logic [LSQ_OP_W-1:0] OP_SH  = 6'd7;
    localparam logic [LSQ_OP_W-1:0] OP_SW  = 6'd8;

    // mem_size encodings
    localparam logic [1:0] SIZE_WORD = 2'd0;
    localparam logic [1:0] SIZE_BYTE = 2'd1;
    localparam logic [1:0] SIZE_HALF = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_RESP     = 2'd2,
        ST_DRAIN    = 2'd3
    } lsq_state_e;

    // Only the low 12 bits of the offset are meaningful, so only those are kept.
    typedef struct packed {
        logic                 valid;
        logic [LSQ_OP_W-1:0]  op;
        logic [LSQ_TAG_W-1:0] tag;
        logic [11:0]          imm;
        logic [LSQ_TAG_W-1:0] q1;
        logic [31:0]          v1;
        logic [LSQ_TAG_W-1:0] q2;
        logic [31:0]          v2;
        logic                 reported;
        logic                 committed;
    } lsq_entry_t;

    function automatic logic is_load(input logic [LSQ_OP_W-1:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [LSQ_OP_W-1:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic [1:0] op_size(input logic [LSQ_OP_W-1:0] op);
        logic [1:0] sz;
        sz = SIZE_WORD;
        if (op inside {OP_LB, OP_LBU, OP_SB}) sz = SIZE_BYTE;
        if (op inside {OP_LH, OP_LHU, OP_SH}) sz = SIZE_HALF;
        return sz;
    endfunction

endpackage

// File: rtl/lsq_load_ext.sv
// Load data extension: turns low-justified memory read data into the
// architectural load value according to the load opcode.
module lsq_load_ext
    import lsq_pkg::*;
(
    input  logic [LSQ_OP_W-1:0] op_i,
    input  logic [31:0]         rdata_i,
    output logic [31:0]         data_o
);

    // Sign- or zero-extend byte/half loads; words pass through untouched
    always_comb begin
        data_o = rdata_i;
        case (op_i)
            OP_LB:   data_o = {{24{rdata_i[7]}}, rdata_i[7:0]};
            OP_LBU:  data_o = {24'h000000, rdata_i[7:0]};
            OP_LH:   data_o = {{16{rdata_i[15]}}, rdata_i[15:0]};
            OP_LHU:  data_o = {16'h0000, rdata_i[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsb_queue.sv
// Load/store queue: holds memory ops in program order, snoops the CDB for
// operands, reports store-ready and load results, and issues one memory op
// at a time from the head. Stores reach memory only after ROB commit, and
// committed stores survive a flush.
module lsb_queue
    import lsq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = LSQ_TAG_W,
    parameter int OP_W  = LSQ_OP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_in,
    input  logic             disp_valid,
    input  logic [OP_W-1:0]  disp_op,
    input  logic [TAG_W-1:0] disp_tag,
    input  logic [31:0]      disp_imm,
    input  logic [TAG_W-1:0] disp_q1,
    input  logic [TAG_W-1:0] disp_q2,
    input  logic [31:0]      disp_v1,
    input  logic [31:0]      disp_v2,
    output logic             full_out,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    input  logic             commit_valid,
    input  logic [TAG_W-1:0] commit_tag,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [1:0]       mem_size,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag,
    output logic [31:0]      res_data
);

    localparam int PTR_W = $clog2(DEPTH);
    typedef logic [PTR_W:0] ptr_t;

    // Queue storage and pointers (extra MSB is the wrap bit)
    lsq_entry_t ent_q [DEPTH];
    lsq_entry_t ent_d [DEPTH];
    lsq_entry_t snp   [DEPTH];
    ptr_t       head_q, head_d, tail_q, tail_d;
    ptr_t       count;
    ptr_t       ncomm;

    lsq_state_e state_q, state_d;

    // Issued-op registers; held stable for the whole memory transaction
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [31:0]          mem_wdata_q, mem_wdata_d;
    logic [1:0]           mem_size_q, mem_size_d;
    logic                 iss_we_q, iss_we_d;
    logic [LSQ_OP_W-1:0]  iss_op_q, iss_op_d;
    logic [LSQ_TAG_W-1:0] iss_tag_q, iss_tag_d;

    logic                 res_valid_q, res_valid_d;
    logic [TAG_W-1:0]     res_tag_q, res_tag_d;
    logic [31:0]          res_data_q, res_data_d;

    logic [DEPTH-1:0]     sr_cand, cm_cand;
    logic                 sr_found, cm_found;
    logic [PTR_W-1:0]     sr_idx, cm_idx;
    logic [PTR_W-1:0]     head_idx, tail_idx;
    lsq_entry_t           head_ent;
    lsq_entry_t           new_ent;
    logic                 cdb_hit;
    logic                 disp_fire, issue_fire, load_done, store_done, dequeue;
    logic [31:0]          ext_data;
    logic                 unused_imm_hi;

    assign unused_imm_hi = ^disp_imm[31:12];

    assign count    = tail_q - head_q;
    assign full_out = (count == ptr_t'(DEPTH));
    assign head_idx = head_q[PTR_W-1:0];
    assign tail_idx = tail_q[PTR_W-1:0];
    assign head_ent = ent_q[head_idx];
    assign cdb_hit  = cdb_valid && (cdb_tag != '0);

    function automatic lsq_entry_t snoop(input lsq_entry_t e, input logic hit,
                                         input logic [TAG_W-1:0] t, input logic [31:0] d);
        lsq_entry_t r;
        r = e;
        if (hit && e.valid && (e.q1 == t)) begin
            r.q1 = '0;
            r.v1 = d;
        end
        if (hit && e.valid && (e.q2 == t)) begin
            r.q2 = '0;
            r.v2 = d;
        end
        return r;
    endfunction

    // Per-entry CDB capture and store-ready / commit candidate flags
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign snp[gi]     = snoop(ent_q[gi], cdb_hit, cdb_tag, cdb_data);
        assign sr_cand[gi] = ent_q[gi].valid && is_store(ent_q[gi].op) &&
                             (ent_q[gi].q1 == '0) && (ent_q[gi].q2 == '0) &&
                             !ent_q[gi].reported;
        assign cm_cand[gi] = ent_q[gi].valid && is_store(ent_q[gi].op) &&
                             !ent_q[gi].committed;
    end

    // Find the oldest store-ready candidate and the oldest uncommitted store
    always_comb begin : age_search
        logic [PTR_W-1:0] idx;
        idx      = '0;
        sr_found = 1'b0;
        sr_idx   = '0;
        cm_found = 1'b0;
        cm_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_idx + PTR_W'(i);
            if (ptr_t'(i) < count) begin
                if (!sr_found && sr_cand[idx]) begin
                    sr_found = 1'b1;
                    sr_idx   = idx;
                end
                if (!cm_found && cm_cand[idx]) begin
                    cm_found = 1'b1;
                    cm_idx   = idx;
                end
            end
        end
    end

    assign disp_fire  = disp_valid && !full_out && !flush_in;
    assign issue_fire = (state_q == ST_IDLE) && !flush_in && (count != '0) && head_ent.valid &&
                        ((is_load(head_ent.op) && (head_ent.q1 == '0)) ||
                         (is_store(head_ent.op) && head_ent.committed &&
                          (head_ent.q1 == '0) && (head_ent.q2 == '0)));
    // A load in flight during a flush is drained and its data discarded
    assign load_done  = (state_q == ST_WAIT_ACK) && mem_ack && !iss_we_q && !flush_in;
    assign store_done = (state_q == ST_WAIT_ACK) && mem_ack && iss_we_q;
    assign dequeue    = load_done || store_done;

    lsq_load_ext u_load_ext (
        .op_i    (iss_op_q),
        .rdata_i (mem_rdata),
        .data_o  (ext_data)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state: issue, wait for ack, optional result cycle, drain on flush
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_fire) state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (flush_in && !iss_we_q) state_d = mem_ack ? ST_IDLE : ST_DRAIN;
                else if (mem_ack)          state_d = iss_we_q ? ST_IDLE : ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            ST_DRAIN: begin
                if (mem_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: request stays up through WAIT_ACK and DRAIN
    always_comb begin
        mem_req = (state_q == ST_WAIT_ACK) || (state_q == ST_DRAIN);
        mem_we  = (state_q == ST_WAIT_ACK) && iss_we_q;
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_size  = mem_size_q;
    assign res_valid = res_valid_q;
    assign res_tag   = res_tag_q;
    assign res_data  = res_data_q;

    // Next queue contents: snoop, commit, report, issue, dequeue, dispatch, flush
    always_comb begin
        for (int i = 0; i < DEPTH; i++) ent_d[i] = snp[i];
        head_d      = head_q;
        tail_d      = tail_q;
        ncomm       = '0;
        new_ent     = '0;
        res_valid_d = 1'b0;
        res_tag_d   = res_tag_q;
        res_data_d  = res_data_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_size_d  = mem_size_q;
        iss_we_d    = iss_we_q;
        iss_op_d    = iss_op_q;
        iss_tag_d   = iss_tag_q;

        if (commit_valid && cm_found && (ent_q[cm_idx].tag == commit_tag))
            ent_d[cm_idx].committed = 1'b1;

        // Load result has priority; a blocked store-ready is retried next cycle
        if (load_done) begin
            res_valid_d = 1'b1;
            res_tag_d   = iss_tag_q;
            res_data_d  = ext_data;
        end else if (sr_found && !flush_in) begin
            res_valid_d = 1'b1;
            res_tag_d   = ent_q[sr_idx].tag;
            res_data_d  = '0;
            ent_d[sr_idx].reported = 1'b1;
        end

        if (issue_fire) begin
            mem_addr_d  = head_ent.v1 + {{20{head_ent.imm[11]}}, head_ent.imm};
            mem_wdata_d = is_store(head_ent.op) ? head_ent.v2 : 32'h0;
            mem_size_d  = op_size(head_ent.op);
            iss_we_d    = is_store(head_ent.op);
            iss_op_d    = head_ent.op;
            iss_tag_d   = head_ent.tag;
        end

        if (dequeue) begin
            ent_d[head_idx].valid = 1'b0;
            head_d = head_q + ptr_t'(1);
        end

        if (disp_fire) begin
            new_ent.valid = 1'b1;
            new_ent.op    = disp_op;
            new_ent.tag   = disp_tag;
            new_ent.imm   = disp_imm[11:0];
            new_ent.q1    = disp_q1;
            new_ent.v1    = disp_v1;
            new_ent.q2    = disp_q2;
            new_ent.v2    = disp_v2;
            if (cdb_hit && (disp_q1 == cdb_tag)) begin
                new_ent.q1 = '0;
                new_ent.v1 = cdb_data;
            end
            if (cdb_hit && (disp_q2 == cdb_tag)) begin
                new_ent.q2 = '0;
                new_ent.v2 = cdb_data;
            end
            ent_d[tail_idx] = new_ent;
            tail_d = tail_q + ptr_t'(1);
        end

        // Committed stores form a prefix from the head, so they alone remain
        if (flush_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!ent_d[i].committed) ent_d[i].valid = 1'b0;
                ncomm = ncomm + ptr_t'(ent_d[i].valid);
            end
            tail_d = head_d + ncomm;
        end
    end

    // Queue, issue and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= SIZE_WORD;
            iss_we_q    <= 1'b0;
            iss_op_q    <= '0;
            iss_tag_q   <= '0;
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_data_q  <= '0;
        end else begin
            ent_q       <= ent_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_size_q  <= mem_size_d;
            iss_we_q    <= iss_we_d;
            iss_op_q    <= iss_op_d;
            iss_tag_q   <= iss_tag_d;
            res_valid_q <= res_valid_d;
            res_tag_q   <= res_tag_d;
            res_data_q  <= res_data_d;
        end
    end

endmodule

// File: tb/tb_lsb_queue.sv
// Directed testbench for lsb_queue: load extension, store-ready/commit flow,
// full/wrap behaviour, flush with committed stores and flush during a load.
module tb_lsb_queue;
    import lsq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_in;
    logic        disp_valid;
    logic [5:0]  disp_op;
    logic [4:0]  disp_tag;
    logic [31:0] disp_imm;
    logic [4:0]  disp_q1, disp_q2;
    logic [31:0] disp_v1, disp_v2;
    logic        full_out;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        commit_valid;
    logic [4:0]  commit_tag;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        res_valid;
    logic [4:0]  res_tag;
    logic [31:0] res_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lsb_queue #(.DEPTH(8), .TAG_W(5), .OP_W(6)) dut (
        .clk(clk), .rst(rst), .flush_in(flush_in),
        .disp_valid(disp_valid), .disp_op(disp_op), .disp_tag(disp_tag), .disp_imm(disp_imm),
        .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_v1(disp_v1), .disp_v2(disp_v2),
        .full_out(full_out),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .commit_valid(commit_valid), .commit_tag(commit_tag),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    task automatic dispatch(input logic [5:0] op, input logic [4:0] tag, input logic [31:0] imm,
                            input logic [4:0] q1, input logic [31:0] v1,
                            input logic [4:0] q2, input logic [31:0] v2);
        disp_valid = 1'b1; disp_op = op; disp_tag = tag; disp_imm = imm;
        disp_q1 = q1; disp_v1 = v1; disp_q2 = q2; disp_v2 = v2;
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 20 && !mem_req; i++) tick();
        check(name, 32'(mem_req), 32'd1);
    endtask

    task automatic wait_res(input string name);
        for (int i = 0; i < 20 && !res_valid; i++) tick();
        check(name, 32'(res_valid), 32'd1);
    endtask

    task automatic ack(input logic [31:0] rdata);
        mem_ack = 1'b1; mem_rdata = rdata;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic cdb(input logic [4:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
        tick();
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic commit(input logic [4:0] tag);
        commit_valid = 1'b1; commit_tag = tag;
        tick();
        commit_valid = 1'b0; commit_tag = '0;
    endtask

    task automatic load_check(input string name, input logic [5:0] op, input logic [4:0] tag,
                              input logic [1:0] size, input logic [31:0] rdata, input logic [31:0] exp);
        dispatch(op, tag, 32'h0, 5'd0, 32'h200, 5'd0, 32'h0);
        wait_req({name, "_req"});
        check({name, "_size"}, 32'(mem_size), 32'(size));
        ack(rdata);
        check({name, "_rvalid"}, 32'(res_valid), 32'd1);
        check({name, "_rtag"}, 32'(res_tag), 32'(tag));
        check({name, "_rdata"}, res_data, exp);
        tick();
    endtask

    logic [4:0] exp_tags [8];

    initial begin
        rst = 1'b1; flush_in = 1'b0; disp_valid = 1'b0; disp_op = '0; disp_tag = '0;
        disp_imm = '0; disp_q1 = '0; disp_q2 = '0; disp_v1 = '0; disp_v2 = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; commit_valid = 1'b0; commit_tag = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        exp_tags = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd10};
        repeat (3) tick();

        // Reset state
        check("rst_full", 32'(full_out), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_size", 32'(mem_size), 32'd0);
        check("rst_rvalid", 32'(res_valid), 32'd0);
        check("rst_rtag", 32'(res_tag), 32'd0);
        check("rst_rdata", res_data, 32'h0);
        rst = 1'b0;
        tick();

        // LW with negative offset
        dispatch(OP_LW, 5'd1, 32'hFFFFFFFC, 5'd0, 32'h104, 5'd0, 32'h0);
        wait_req("lw_req");
        check("lw_addr", mem_addr, 32'h100);
        check("lw_size", 32'(mem_size), 32'd0);
        check("lw_we", 32'(mem_we), 32'd0);
        ack(32'hDEADBEEF);
        check("lw_rvalid", 32'(res_valid), 32'd1);
        check("lw_rtag", 32'(res_tag), 32'd1);
        check("lw_rdata", res_data, 32'hDEADBEEF);
        check("lw_req_drop", 32'(mem_req), 32'd0);
        tick();
        check("lw_pulse", 32'(res_valid), 32'd0);

        // Byte / half extension
        load_check("lb", OP_LB, 5'd2, 2'd1, 32'h00000080, 32'hFFFFFF80);
        load_check("lbu", OP_LBU, 5'd3, 2'd1, 32'h00000080, 32'h00000080);
        load_check("lh", OP_LH, 5'd4, 2'd2, 32'h00008001, 32'hFFFF8001);

        // Store waiting on CDB data, store-ready, then commit
        dispatch(OP_SW, 5'd9, 32'h4, 5'd0, 32'h300, 5'd7, 32'h0);
        tick();
        check("sw_no_early_res", 32'(res_valid), 32'd0);
        cdb(5'd7, 32'h55);
        wait_res("sw_ready");
        check("sw_ready_tag", 32'(res_tag), 32'd9);
        check("sw_ready_data", res_data, 32'h0);
        commit(5'd8);
        repeat (3) tick();
        check("sw_no_req_badcommit", 32'(mem_req), 32'd0);
        check("sw_no_repeat_res", 32'(res_valid), 32'd0);
        commit(5'd9);
        wait_req("sw_req");
        check("sw_we", 32'(mem_we), 32'd1);
        check("sw_wdata", mem_wdata, 32'h55);
        check("sw_addr", mem_addr, 32'h304);
        ack(32'h0);
        check("sw_no_res", 32'(res_valid), 32'd0);
        check("sw_req_drop", 32'(mem_req), 32'd0);
        tick();

        // Fill to full, extra dispatch dropped, dequeue then wrapped dispatch
        for (int k = 1; k <= 8; k++)
            dispatch(OP_LW, 5'(k), 32'h0, 5'd20, 32'h0, 5'd0, 32'h0);
        check("fill_full", 32'(full_out), 32'd1);
        dispatch(OP_LW, 5'd9, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        check("fill_still_full", 32'(full_out), 32'd1);
        check("fill_no_issue", 32'(mem_req), 32'd0);
        cdb(5'd20, 32'h400);
        wait_req("fill_req1");
        check("fill_addr1", mem_addr, 32'h400);
        disp_valid = 1'b1; disp_op = OP_LW; disp_tag = 5'd11; disp_q1 = 5'd0; disp_v1 = 32'h0;
        ack(32'h1000);
        disp_valid = 1'b0;
        check("deq_not_full", 32'(full_out), 32'd0);
        check("deq_rtag", 32'(res_tag), 32'd1);
        dispatch(OP_LW, 5'd10, 32'h0, 5'd0, 32'h500, 5'd0, 32'h0);
        check("wrap_full", 32'(full_out), 32'd1);
        for (int k = 0; k < 8; k++) begin
            wait_req("drain_req");
            ack(32'h2000 + 32'(k));
            check("drain_rvalid", 32'(res_valid), 32'd1);
            check("drain_rtag", 32'(res_tag), 32'(exp_tags[k]));
            check("drain_rdata", res_data, 32'h2000 + 32'(k));
        end
        tick();
        check("drain_empty_req", 32'(mem_req), 32'd0);

        // Flush keeps two committed stores, drops three uncommitted ops
        dispatch(OP_SW, 5'd12, 32'h0, 5'd0, 32'h600, 5'd0, 32'hA1);
        dispatch(OP_SW, 5'd13, 32'h0, 5'd0, 32'h604, 5'd0, 32'hA2);
        dispatch(OP_LW, 5'd14, 32'h0, 5'd21, 32'h0, 5'd0, 32'h0);
        dispatch(OP_SW, 5'd15, 32'h0, 5'd0, 32'h608, 5'd22, 32'h0);
        dispatch(OP_LW, 5'd16, 32'h0, 5'd23, 32'h0, 5'd0, 32'h0);
        commit(5'd12);
        commit(5'd13);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        check("fl_res_clear", 32'(res_valid), 32'd0);
        cdb(5'd21, 32'h0);
        cdb(5'd22, 32'h0);
        cdb(5'd23, 32'h0);
        check("fl_no_res_after_cdb", 32'(res_valid), 32'd0);
        dispatch(OP_LW, 5'd17, 32'h0, 5'd0, 32'h700, 5'd0, 32'h0);
        wait_req("fl_st1_req");
        check("fl_st1_we", 32'(mem_we), 32'd1);
        check("fl_st1_addr", mem_addr, 32'h600);
        check("fl_st1_wdata", mem_wdata, 32'hA1);
        ack(32'h0);
        check("fl_st1_no_res", 32'(res_valid), 32'd0);
        wait_req("fl_st2_req");
        check("fl_st2_we", 32'(mem_we), 32'd1);
        check("fl_st2_addr", mem_addr, 32'h604);
        check("fl_st2_wdata", mem_wdata, 32'hA2);
        ack(32'h0);
        check("fl_st2_no_res", 32'(res_valid), 32'd0);
        wait_req("fl_ld_req");
        check("fl_ld_we", 32'(mem_we), 32'd0);
        check("fl_ld_addr", mem_addr, 32'h700);
        ack(32'h77);
        check("fl_ld_rtag", 32'(res_tag), 32'd17);
        check("fl_ld_rdata", res_data, 32'h77);
        tick();

        // Flush while a load waits for its ack
        dispatch(OP_LW, 5'd18, 32'h0, 5'd0, 32'h800, 5'd0, 32'h0);
        wait_req("dr_req");
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        check("dr_req_held", 32'(mem_req), 32'd1);
        dispatch(OP_LW, 5'd24, 32'h0, 5'd0, 32'hA00, 5'd0, 32'h0);
        tick();
        check("dr_req_held2", 32'(mem_req), 32'd1);
        check("dr_addr_stable", mem_addr, 32'h800);
        ack(32'h1234);
        check("dr_no_res", 32'(res_valid), 32'd0);
        check("dr_req_drop", 32'(mem_req), 32'd0);
        tick();
        check("dr_no_res2", 32'(res_valid), 32'd0);
        wait_req("dr_next_req");
        check("dr_next_addr", mem_addr, 32'hA00);
        ack(32'hCAFE0001);
        check("dr_next_rvalid", 32'(res_valid), 32'd1);
        check("dr_next_rtag", 32'(res_tag), 32'd24);
        check("dr_next_rdata", res_data, 32'hCAFE0001);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
